// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Optional feature macro used by the top: NIBBLE_SERIAL_ADDER_SUB_EN (adds subtract mode).
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of nibbles needed to cover a WIDTH-bit operand.
    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

    // Width of the nibble index register; never narrower than one bit.
    function automatic int idx_width(input int width);
        int n;
        n = width / NIBBLE_W;
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/nibble_cla4.sv
// Purely combinational 4-bit carry-lookahead slice. c[i] is the carry out of
// bit i, so c[3] is the slice carry-out and c[2] is the carry into bit 3.
module nibble_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic [3:0] c
);

    logic [3:0] g_s;
    logic [3:0] p_s;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g_s  = a & b;
        p_s  = a ^ b;
        c[0] = g_s[0] | (p_s[0] & cin);
        c[1] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c[2] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
             | (p_s[2] & p_s[1] & p_s[0] & cin);
        c[3] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
             | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
        sum  = p_s ^ {c[2:0], cin};
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single 4-bit CLA,
// least significant nibble first, carry registered between nibbles.
// Optional macro NIBBLE_SERIAL_ADDER_SUB_EN adds a 'sub' port (a - b mode).
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDXW  = idx_width(WIDTH);
    localparam int NSLOT = 2 ** IDXW;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    generate
        if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IDXW-1:0]   idx_r;
    logic              carry_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;
    logic              ovf_r;

    logic [WIDTH-1:0]  b_cap_s;
    logic              c_cap_s;
    logic [3:0]        a_nib_s [NSLOT];
    logic [3:0]        b_nib_s [NSLOT];
    logic [3:0]        cla_sum_s;
    logic [3:0]        cla_c_s;
    logic              last_s;

    // Nibble views of the operand registers; unused index slots read as zero
    // so the selector index always matches the array size exactly.
    generate
        for (genvar g = 0; g < NSLOT; g++) begin : g_nib
            if (g < NIB) begin : g_used
                assign a_nib_s[g] = a_r[g*NIBBLE_W +: NIBBLE_W];
                assign b_nib_s[g] = b_r[g*NIBBLE_W +: NIBBLE_W];
            end else begin : g_unused
                assign a_nib_s[g] = 4'b0000;
                assign b_nib_s[g] = 4'b0000;
            end
        end
    endgenerate

    nibble_cla4 u_cla (
        .a   (a_nib_s[idx_r]),
        .b   (b_nib_s[idx_r]),
        .cin (carry_r),
        .sum (cla_sum_s),
        .c   (cla_c_s)
    );

    assign last_s    = (idx_r == IDX_LAST);
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // Operand B and initial carry as captured at accept (inverted B, carry 1 for subtract).
    always_comb begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_cap_s = ~b;
            c_cap_s = 1'b1;
        end else begin
            b_cap_s = b;
            c_cap_s = cin;
        end
`else
        b_cap_s = b;
        c_cap_s = cin;
`endif
    end

    // Next-state decode for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, per-nibble sum accumulation and final flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b_cap_s;
                        carry_r <= c_cap_s;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    carry_r <= cla_c_s[3];
                    for (int i = 0; i < NIB; i++) begin
                        if (idx_r == IDXW'(i)) begin
                            sum_r[i*NIBBLE_W +: NIBBLE_W] <= cla_sum_s;
                        end
                    end
                    if (last_s) begin
                        cout_r <= cla_c_s[3];
                        ovf_r  <= cla_c_s[2] ^ cla_c_s[3];
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: a WIDTH=16 instance checked every
// cycle against an arithmetic model, plus a WIDTH=4 instance checked by hand.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, out_ready, cin, sub;
    logic [W-1:0]  a, b;
    logic          in_ready, out_valid, cout, ovf;
    logic [W-1:0]  sum;

    logic          in_valid4, out_ready4, cin4;
    logic [3:0]    a4, b4, sum4;
    logic          in_ready4, out_valid4, cout4, ovf4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {cout, ovf, sum}.
    function automatic logic [W+1:0] model_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic ci, input logic sb);
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   full;
        logic         v;
        yy = y;
        cc = ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        if (sb) begin
            yy = ~y;
            cc = 1'b1;
        end
`endif
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        v = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return {full[W], v, full[W-1:0]};
    endfunction

    // Protocol-level model: operation takes NIB cycles, result held until retired.
    logic          m_busy, m_done, m_cout, m_ovf;
    int            m_cnt;
    logic [W-1:0]  m_sum;
    logic [W+1:0]  p_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
            m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0; p_res <= '0;
        end else if (!m_busy && !m_done) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= NIB - 1;
                p_res  <= model_op(a, b, cin, sub);
            end
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_cout, m_ovf, m_sum} <= p_res;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (out_ready) begin
            m_done <= 1'b0;
        end
    end

    // Every-cycle comparison of the WIDTH=16 instance against the model.
    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(m_busy || m_done)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
        if (!m_busy) begin
            chk("sum", {16'd0, sum}, {16'd0, m_sum});
            chk("cout", {31'd0, cout}, {31'd0, m_cout});
            chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
        end
    end

    // Present operands, wait for the result, pin it to literals, then retire it.
    task automatic run_op(input string nm, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        @(posedge clk); #2;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        chk({nm, "_latency"}, lat, NIB);
        chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] hs;
        logic hc, ho;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        a = '0; b = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        #1 rst_n = 1'b0;
        #20;
        chk("reset_sum", {16'd0, sum}, 32'h0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // WIDTH=4: single RUN cycle.
        @(posedge clk); #2;
        a4 = 4'b1101; b4 = 4'b1110; cin4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #2;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("w4_latency", lat, 1);
        chk("w4_sum", {28'd0, sum4}, 32'hB);
        chk("w4_cout", {31'd0, cout4}, 32'd1);
        chk("w4_ovf", {31'd0, ovf4}, 32'd0);
        out_ready4 = 1'b1;
        @(posedge clk); #2;
        out_ready4 = 1'b0;
        chk("w4_retired", {30'd0, out_valid4, in_ready4}, 32'd1);

        run_op("chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("allones", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Backpressure: result must hold while new operands wait.
        @(posedge clk); #2;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #2;
        a = 16'hAAAA; b = 16'h0001;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("bp_latency", lat, NIB);
        hs = sum; hc = cout; ho = ovf;
        chk("bp_first_sum", {16'd0, hs}, 32'h5555);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("bp_hold_sum", {16'd0, sum}, {16'd0, hs});
            chk("bp_hold_flags", {30'd0, cout, ovf}, {30'd0, hc, ho});
            chk("bp_hold_ready", {30'd0, in_ready, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        chk("bp_idle", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clk); #2;
        chk("bp_taken", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("bp_second_sum", {16'd0, sum}, 32'hAAAB);
        chk("bp_second_flags", {30'd0, cout, ovf}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;

        // Reset after two nibbles of an operation.
        @(posedge clk); #2;
        a = 16'hFFFF; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #1 rst_n = 1'b1;
        run_op("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
